utest_sequencer: RTL and testbench

- Synthesizable, parametrised successor to the bench-level micro-test switcher.
- Watches the control unit's micro-PC stream and runs a table of NTESTS microcode self-tests in order.
- For each test it detects a pass condition (jump from a source address to a target address) or a fail label, or a timeout. It then requests a micro-PC redirect to the next test's entry point.
- Sits beside the control unit; drives uPC force via a valid/ack redirect handshake and exposes pass/fail status to the trace/diagnostic logic.

---
 rtl/utest_sequencer_if.sv | 22 ++
 rtl/utest_sequencer.sv | 171 +++++++++++++++++
 tb/tb_utest_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/utest_sequencer_if.sv
// Micro-PC observation stream and redirect handshake between the control unit and the self-test sequencer.
// master = sequencer side, slave = control unit side.
interface utest_sequencer_if #(
  parameter int UAW = 12
);
  logic           pc_valid;
  logic [UAW-1:0] pc_x;
  logic [UAW-1:0] pc_f;
  logic           redir_valid;
  logic [UAW-1:0] redir_addr;
  logic           redir_ack;

  modport master (
    input  pc_valid, pc_x, pc_f, redir_ack,
    output redir_valid, redir_addr
  );

  modport slave (
    output pc_valid, pc_x, pc_f, redir_ack,
    input  redir_valid, redir_addr
  );
endinterface

// File: rtl/utest_sequencer.sv
// Runs a table of microcode self-tests by watching the micro-PC and redirecting it; events show up one cycle later.
// A redirect is held until redir_ack; matching and the timeout counter pause while it is outstanding.
module utest_sequencer #(
  parameter int  NTESTS       = 8,
  parameter int  UAW          = 12,
  parameter int  TOW          = 16,
  parameter bit  STOP_ON_FAIL = 1'b1,
  localparam int IW           = $clog2(NTESTS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cfg_we,
  input  logic [IW-1:0]           cfg_idx,
  input  logic [1:0]              cfg_sel,
  input  logic [UAW-1:0]          cfg_data,
  input  logic                    start,
  utest_sequencer_if.master       cu,
  output logic                    busy,
  output logic                    done,
  output logic [IW-1:0]           cur_test,
  output logic [NTESTS-1:0]       pass_mask,
  output logic [NTESTS-1:0]       fail_mask,
  output logic                    timeout
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_REDIR, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [UAW-1:0]    entry_q [NTESTS];
  logic [UAW-1:0]    entry_d [NTESTS];
  logic [UAW-1:0]    from_q  [NTESTS];
  logic [UAW-1:0]    from_d  [NTESTS];
  logic [UAW-1:0]    to_q    [NTESTS];
  logic [UAW-1:0]    to_d    [NTESTS];
  logic [UAW-1:0]    flab_q  [NTESTS];
  logic [UAW-1:0]    flab_d  [NTESTS];
  logic [IW-1:0]     cur_q, cur_d;
  logic [NTESTS-1:0] pass_q, pass_d;
  logic [NTESTS-1:0] fail_q, fail_d;
  logic              tmo_q, tmo_d;
  logic              done_q, done_d;
  logic              rv_q, rv_d;
  logic [UAW-1:0]    ra_q, ra_d;
  logic [TOW-1:0]    cnt_q, cnt_d;

  logic          fail_hit, pass_hit, tmo_hit, is_fail, last;
  logic [IW-1:0] nxt;

  // Fail label outranks a simultaneous pass jump; the timeout only counts when nothing matched.
  assign fail_hit = cu.pc_valid && (cu.pc_x == flab_q[cur_q]);
  assign pass_hit = cu.pc_valid && (cu.pc_x == to_q[cur_q]) && (cu.pc_f == from_q[cur_q]);
  assign tmo_hit  = (cnt_q == {TOW{1'b1}});
  assign is_fail  = fail_hit || (!pass_hit && tmo_hit);
  assign last     = (cur_q == IW'(NTESTS - 1));
  assign nxt      = last ? cur_q : cur_q + IW'(1);

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    from_d  = from_q;
    to_d    = to_q;
    flab_d  = flab_q;
    cur_d   = cur_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    tmo_d   = tmo_q;
    done_d  = done_q;
    rv_d    = rv_q;
    ra_d    = ra_q;
    cnt_d   = cnt_q;

    if (cfg_we && (state_q == S_IDLE || state_q == S_DONE)) begin
      case (cfg_sel)
        2'd0:    entry_d[cfg_idx] = cfg_data;
        2'd1:    from_d[cfg_idx]  = cfg_data;
        2'd2:    to_d[cfg_idx]    = cfg_data;
        default: flab_d[cfg_idx]  = cfg_data;
      endcase
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pass_d  = '0;
          fail_d  = '0;
          tmo_d   = 1'b0;
          done_d  = 1'b0;
          cur_d   = '0;
          cnt_d   = '0;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        ra_d    = entry_q[cur_q];
        rv_d    = 1'b1;
        state_d = S_REDIR;
      end
      S_REDIR: begin
        if (cu.redir_ack) begin
          rv_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (fail_hit || pass_hit || tmo_hit) begin
          if (is_fail) fail_d[cur_q] = 1'b1;
          else         pass_d[cur_q] = 1'b1;
          if (!fail_hit && !pass_hit) tmo_d = 1'b1;
          if ((is_fail && STOP_ON_FAIL) || last) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            cur_d   = nxt;
            cnt_d   = '0;
            ra_d    = entry_q[nxt];
            rv_d    = 1'b1;
            state_d = S_REDIR;
          end
        end else begin
          cnt_d = cnt_q + TOW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NTESTS; i++) begin
        entry_q[i] <= '0;
        from_q[i]  <= '0;
        to_q[i]    <= '0;
        flab_q[i]  <= '0;
      end
      cur_q  <= '0;
      pass_q <= '0;
      fail_q <= '0;
      tmo_q  <= 1'b0;
      done_q <= 1'b0;
      rv_q   <= 1'b0;
      ra_q   <= '0;
      cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      from_q  <= from_d;
      to_q    <= to_d;
      flab_q  <= flab_d;
      cur_q   <= cur_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      rv_q    <= rv_d;
      ra_q    <= ra_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cu.redir_valid = rv_q;
  assign cu.redir_addr  = ra_q;
  assign busy           = (state_q == S_LAUNCH) || (state_q == S_RUN) || (state_q == S_REDIR);
  assign done           = done_q;
  assign cur_test       = cur_q;
  assign pass_mask      = pass_q;
  assign fail_mask      = fail_q;
  assign timeout        = tmo_q;

endmodule

// File: tb/tb_utest_sequencer.sv
// Two sequencers share all stimulus: dut_s stops on the first failure, dut_c keeps going.
// Both use a two-slot table and a 4-bit timeout counter.
module tb_utest_sequencer;
  localparam int NT  = 2;
  localparam int UAW = 12;
  localparam int TOW = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           cfg_we, start, pc_valid, redir_ack;
  logic [0:0]     cfg_idx;
  logic [1:0]     cfg_sel;
  logic [UAW-1:0] cfg_data, pc_x, pc_f;

  logic           s_busy, s_done, s_to, c_busy, c_done, c_to;
  logic [0:0]     s_cur, c_cur;
  logic [NT-1:0]  s_pass, s_fail, c_pass, c_fail;

  int checks = 0;
  int errors = 0;
  logic [41:0] exp;

  always #5 clk = ~clk;

  utest_sequencer_if #(.UAW(UAW)) ifs ();
  utest_sequencer_if #(.UAW(UAW)) ifc ();

  assign ifs.pc_valid  = pc_valid;
  assign ifs.pc_x      = pc_x;
  assign ifs.pc_f      = pc_f;
  assign ifs.redir_ack = redir_ack;
  assign ifc.pc_valid  = pc_valid;
  assign ifc.pc_x      = pc_x;
  assign ifc.pc_f      = pc_f;
  assign ifc.redir_ack = redir_ack;

  utest_sequencer #(.NTESTS(NT), .UAW(UAW), .TOW(TOW), .STOP_ON_FAIL(1'b1)) dut_s (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .start(start), .cu(ifs), .busy(s_busy), .done(s_done),
    .cur_test(s_cur), .pass_mask(s_pass), .fail_mask(s_fail), .timeout(s_to)
  );

  utest_sequencer #(.NTESTS(NT), .UAW(UAW), .TOW(TOW), .STOP_ON_FAIL(1'b0)) dut_c (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .start(start), .cu(ifc), .busy(c_busy), .done(c_done),
    .cur_test(c_cur), .pass_mask(c_pass), .fail_mask(c_fail), .timeout(c_to)
  );

  // Snapshot layout: {redir_valid, redir_addr, busy, done, cur_test, pass_mask, fail_mask, timeout}
  function automatic logic [20:0] snap(input bit c);
    if (c) return {ifc.redir_valid, ifc.redir_addr, c_busy, c_done, c_cur, c_pass, c_fail, c_to};
    return {ifs.redir_valid, ifs.redir_addr, s_busy, s_done, s_cur, s_pass, s_fail, s_to};
  endfunction

  function automatic logic [20:0] ex(input logic v, input logic [11:0] a, input logic b,
                                     input logic d, input logic cur, input logic [1:0] p,
                                     input logic [1:0] f, input logic t);
    return {v, a, b, d, cur, p, f, t};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic idx, input logic [1:0] sel, input logic [11:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_sel = sel; cfg_data = d;
    tick;
    cfg_we = 1'b0;
  endtask

  task automatic load_default;
    cfg_write(1'b0, 2'd0, 12'd0);  cfg_write(1'b0, 2'd1, 12'd1);
    cfg_write(1'b0, 2'd2, 12'd6);  cfg_write(1'b0, 2'd3, 12'd7);
    cfg_write(1'b1, 2'd0, 12'd8);  cfg_write(1'b1, 2'd1, 12'd9);
    cfg_write(1'b1, 2'd2, 12'd14); cfg_write(1'b1, 2'd3, 12'd15);
  endtask

  // start pulse, then the LAUNCH cycle: afterwards both DUTs sit in REDIR
  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
  endtask

  task automatic do_ack;
    redir_ack = 1'b1;
    tick;
    redir_ack = 1'b0;
  endtask

  task automatic do_pc(input logic [11:0] x, input logic [11:0] f);
    pc_valid = 1'b1; pc_x = x; pc_f = f;
    tick;
    pc_valid = 1'b0;
  endtask

  task automatic test_reset;
    tick;
    tick;
    exp = '0;
    checks++;
    if ({snap(0), snap(1)} !== exp) begin
      errors++; $display("FAIL reset_state: got %h want %h", {snap(0), snap(1)}, exp);
    end
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_pass_run;
    load_default;
    do_start;
    exp = {ex(1, 12'd0, 1, 0, 0, 2'b00, 2'b00, 0), ex(1, 12'd0, 1, 0, 0, 2'b00, 2'b00, 0)};
    checks++;
    if ({snap(0), snap(1)} !== exp) begin
      errors++; $display("FAIL launch_redir0: got %h want %h", {snap(0), snap(1)}, exp);
    end
    do_ack;
    exp = {ex(0, 12'd0, 1, 0, 0, 2'b00, 2'b00, 0), ex(0, 12'd0, 1, 0, 0, 2'b00, 2'b00, 0)};
    checks++;
    if ({snap(0), snap(1)} !== exp) begin
      errors++; $display("FAIL ack_to_run: got %h want %h", {snap(0), snap(1)}, exp);
    end
    do_pc(12'd6, 12'd1);
    exp = {ex(1, 12'd8, 1, 0, 1, 2'b01, 2'b00, 0), ex(1, 12'd8, 1, 0, 1, 2'b01, 2'b00, 0)};
    checks++;
    if ({snap(0), snap(1)} !== exp) begin
      errors++; $display("FAIL pass0_redir8: got %h want %h", {snap(0), snap(1)}, exp);
    end
    do_ack;
    exp = {ex(0, 12'd8, 1, 0, 1, 2'b01, 2'b00, 0), ex(0, 12'd8, 1, 0, 1, 2'b01, 2'b00, 0)};
    checks++;
    if ({snap(0), snap(1)} !== exp) begin
      errors++; $display("FAIL ack_slot1: got %h want %h", {snap(0), snap(1)}, exp);
    end
    do_pc(12'd14, 12'd9);
    exp = {ex(0, 12'd8, 0, 1, 1, 2'b11, 2'b00, 0), ex(0, 12'd8, 0, 1, 1, 2'b11, 2'b00, 0)};
    checks++;
    if ({snap(0), snap(1)} !== exp) begin
      errors++; $display("FAIL pass_done: got %h want %h", {snap(0), snap(1)}, exp);
    end
  endtask

  task automatic test_fail_label;
    do_start;
    do_ack;
    do_pc(12'd7, 12'd0);
    exp = {ex(0, 12'd0, 0, 1, 0, 2'b00, 2'b01, 0), ex(1, 12'd8, 1, 0, 1, 2'b00, 2'b01, 0)};
    checks++;
    if ({snap(0), snap(1)} !== exp) begin
      errors++; $display("FAIL fail_label: got %h want %h", {snap(0), snap(1)}, exp);
    end
    do_ack;
    do_pc(12'd14, 12'd9);
    exp = {ex(0, 12'd0, 0, 1, 0, 2'b00, 2'b01, 0), ex(0, 12'd8, 0, 1, 1, 2'b10, 2'b01, 0)};
    checks++;
    if ({snap(0), snap(1)} !== exp) begin
      errors++; $display("FAIL fail_then_pass: got %h want %h", {snap(0), snap(1)}, exp);
    end
  endtask

  task automatic test_timeout;
    bit seen;
    seen = 1'b0;
    do_start;
    do_ack;
    pc_valid = 1'b1; pc_x = 12'd100; pc_f = 12'd100;
    for (int i = 0; i < 14; i++) tick;
    checks++;
    if ({s_fail, c_fail, s_to, c_to} !== 6'b0) begin
      errors++; $display("FAIL timeout_early: got %b want 000000", {s_fail, c_fail, s_to, c_to});
    end
    for (int i = 0; i < 4 && !seen; i++) begin
      tick;
      seen = s_fail[0];
    end
    pc_valid = 1'b0;
    exp = {ex(0, 12'd0, 0, 1, 0, 2'b00, 2'b01, 1), ex(1, 12'd8, 1, 0, 1, 2'b00, 2'b01, 1)};
    checks++;
    if (!seen || {snap(0), snap(1)} !== exp) begin
      errors++; $display("FAIL timeout_hit: seen=%0d got %h want %h", seen, {snap(0), snap(1)}, exp);
    end
    do_ack;
    do_pc(12'd14, 12'd9);
    exp = {ex(0, 12'd0, 0, 1, 0, 2'b00, 2'b01, 1), ex(0, 12'd8, 0, 1, 1, 2'b10, 2'b01, 1)};
    checks++;
    if ({snap(0), snap(1)} !== exp) begin
      errors++; $display("FAIL timeout_done: got %h want %h", {snap(0), snap(1)}, exp);
    end
  endtask

  task automatic test_simultaneous;
    cfg_write(1'b0, 2'd3, 12'd6);
    do_start;
    do_ack;
    do_pc(12'd6, 12'd1);
    exp = {ex(0, 12'd0, 0, 1, 0, 2'b00, 2'b01, 0), ex(1, 12'd8, 1, 0, 1, 2'b00, 2'b01, 0)};
    checks++;
    if ({snap(0), snap(1)} !== exp) begin
      errors++; $display("FAIL fail_beats_pass: got %h want %h", {snap(0), snap(1)}, exp);
    end
    do_ack;
    do_pc(12'd14, 12'd9);
    exp = {ex(0, 12'd0, 0, 1, 0, 2'b00, 2'b01, 0), ex(0, 12'd8, 0, 1, 1, 2'b10, 2'b01, 0)};
    checks++;
    if ({snap(0), snap(1)} !== exp) begin
      errors++; $display("FAIL simul_done: got %h want %h", {snap(0), snap(1)}, exp);
    end
    cfg_write(1'b0, 2'd3, 12'd7);
  endtask

  task automatic test_ack_hold;
    do_start;
    do_ack;
    do_pc(12'd6, 12'd1);
    exp = {ex(1, 12'd8, 1, 0, 1, 2'b01, 2'b00, 0), ex(1, 12'd8, 1, 0, 1, 2'b01, 2'b00, 0)};
    for (int i = 0; i < 5; i++) begin
      pc_valid = 1'b1; pc_f = 12'd9;
      pc_x = (i % 2 == 0) ? 12'd14 : 12'd15;
      tick;
      checks++;
      if ({snap(0), snap(1)} !== exp) begin
        errors++; $display("FAIL ack_hold[%0d]: got %h want %h", i, {snap(0), snap(1)}, exp);
      end
    end
    pc_valid = 1'b0;
    do_ack;
    do_pc(12'd14, 12'd9);
    exp = {ex(0, 12'd8, 0, 1, 1, 2'b11, 2'b00, 0), ex(0, 12'd8, 0, 1, 1, 2'b11, 2'b00, 0)};
    checks++;
    if ({snap(0), snap(1)} !== exp) begin
      errors++; $display("FAIL ack_hold_done: got %h want %h", {snap(0), snap(1)}, exp);
    end
  endtask

  task automatic test_cfg_in_run;
    do_start;
    do_ack;
    cfg_write(1'b0, 2'd0, 12'h055);
    cfg_write(1'b1, 2'd0, 12'h066);
    do_pc(12'd6, 12'd1);
    exp = {ex(1, 12'd8, 1, 0, 1, 2'b01, 2'b00, 0), ex(1, 12'd8, 1, 0, 1, 2'b01, 2'b00, 0)};
    checks++;
    if ({snap(0), snap(1)} !== exp) begin
      errors++; $display("FAIL cfg_run_entry1: got %h want %h", {snap(0), snap(1)}, exp);
    end
    do_ack;
    do_pc(12'd14, 12'd9);
    do_start;
    exp = {ex(1, 12'd0, 1, 0, 0, 2'b00, 2'b00, 0), ex(1, 12'd0, 1, 0, 0, 2'b00, 2'b00, 0)};
    checks++;
    if ({snap(0), snap(1)} !== exp) begin
      errors++; $display("FAIL cfg_run_entry0: got %h want %h", {snap(0), snap(1)}, exp);
    end
    do_ack;
    do_pc(12'd6, 12'd1);
    do_ack;
    do_pc(12'd14, 12'd9);
  endtask

  task automatic test_reset_mid_redir;
    do_start;
    do_ack;
    do_pc(12'd6, 12'd1);
    reset_n = 1'b0;
    #1;
    exp = '0;
    checks++;
    if ({snap(0), snap(1)} !== exp) begin
      errors++; $display("FAIL reset_mid_redir: got %h want %h", {snap(0), snap(1)}, exp);
    end
    tick;
    reset_n = 1'b1;
    tick;
    load_default;
    do_start;
    exp = {ex(1, 12'd0, 1, 0, 0, 2'b00, 2'b00, 0), ex(1, 12'd0, 1, 0, 0, 2'b00, 2'b00, 0)};
    checks++;
    if ({snap(0), snap(1)} !== exp) begin
      errors++; $display("FAIL rerun_slot0: got %h want %h", {snap(0), snap(1)}, exp);
    end
    do_ack;
    do_pc(12'd6, 12'd1);
    exp = {ex(1, 12'd8, 1, 0, 1, 2'b01, 2'b00, 0), ex(1, 12'd8, 1, 0, 1, 2'b01, 2'b00, 0)};
    checks++;
    if ({snap(0), snap(1)} !== exp) begin
      errors++; $display("FAIL rerun_redir8: got %h want %h", {snap(0), snap(1)}, exp);
    end
    do_ack;
    do_pc(12'd14, 12'd9);
    exp = {ex(0, 12'd8, 0, 1, 1, 2'b11, 2'b00, 0), ex(0, 12'd8, 0, 1, 1, 2'b11, 2'b00, 0)};
    checks++;
    if ({snap(0), snap(1)} !== exp) begin
      errors++; $display("FAIL rerun_done: got %h want %h", {snap(0), snap(1)}, exp);
    end
  endtask

  initial begin
    cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_data = '0;
    start = 1'b0; pc_valid = 1'b0; pc_x = '0; pc_f = '0; redir_ack = 1'b0;
    test_reset;
    test_pass_run;
    test_fail_label;
    test_timeout;
    test_simultaneous;
    test_ack_hold;
    test_cfg_in_run;
    test_reset_mid_redir;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
